fifo_wptr_full: RTL and testbench

Write-domain pointer and flag controller for the async FIFO.
- Drives the binary write address into the dual-port RAM.
- Produces the registered Gray write pointer that the 2-FF synchronizer (ff_sync) carries into the read domain.
- Takes the read-domain Gray pointer, already synchronized into the write clock by a second ff_sync, and generates full, almost-full, fill level and a sticky overflow flag.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_wptr_full_if.sv | 33 +++
 rtl/fifo_wptr_full.sv | 90 +++++++++
 tb/tb_fifo_wptr_full.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks (write and read side).
// The Gray helpers work on a fixed wide vector so one function serves any
// pointer width up to GW bits; callers zero-extend and slice the result.
package fifo_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int GW         = 16;

  // FIFO depth for a given RAM address width.
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

  // Binary to reflected Gray code.
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code back to binary (prefix XOR from the MSB down).
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the FIFO pointer controller.
// Handshake: winc is a write request; a write is accepted on the clk edge
// where wen is high (wen = winc & ~wfull). A request while wfull is high is
// dropped and recorded in the sticky woverflow flag until clr_ovf.
interface fifo_wptr_full_if
  import fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  localparam int PW = ADDR_W + 1;

  logic              winc;
  logic [PW-1:0]     wq2_rptr;
  logic              clr_ovf;
  logic [ADDR_W-1:0] waddr;
  logic              wen;
  logic [PW-1:0]     wptr;
  logic              wfull;
  logic              walmost_full;
  logic [PW-1:0]     wlevel;
  logic              woverflow;

  modport slave (
    input  winc, wq2_rptr, clr_ovf,
    output waddr, wen, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport master (
    output winc, wq2_rptr, clr_ovf,
    input  waddr, wen, wptr, wfull, walmost_full, wlevel, woverflow
  );

endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag controller of the async FIFO.
// Keeps the binary write pointer (RAM address), publishes a registered Gray
// pointer for the read-side synchronizer, and derives full, almost-full,
// fill level and sticky overflow from the synchronized read Gray pointer.
// Every flag is registered, so wq2_rptr reaches no output combinationally.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_LEVEL = 6
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wptr_full_if.slave   bus
);

  localparam int PW       = ADDR_W + 1;
  localparam int DEPTH    = depth(ADDR_W);
  localparam int AF_CLAMP = (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
  localparam logic [PW-1:0] AF_CMP = PW'(AF_CLAMP);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic          r_full;
  logic          r_af;
  logic [PW-1:0] r_level;
  logic          r_ovf;

  logic          w_wen;
  logic [PW-1:0] w_wbin_next;
  logic [GW-1:0] w_gray_wide;
  logic [PW-1:0] w_gray_next;
  logic [GW-1:0] w_rbin_wide;
  logic [PW-1:0] w_rbin_s;
  logic [PW-1:0] w_full_cmp;
  logic          w_full_next;
  logic [PW-1:0] w_level_next;
  logic          w_af_next;
  logic          w_ovf_next;
  logic          w_unused_hi;

  // Accept only when not full; wbin wraps naturally modulo 2**PW.
  assign w_wen       = bus.winc & ~r_full;
  assign w_wbin_next = r_wbin + {{(PW-1){1'b0}}, w_wen};

  // Gray conversions through the shared package helpers.
  assign w_gray_wide = bin2gray({{(GW-PW){1'b0}}, w_wbin_next});
  assign w_gray_next = w_gray_wide[PW-1:0];
  assign w_rbin_wide = gray2bin({{(GW-PW){1'b0}}, bus.wq2_rptr});
  assign w_rbin_s    = w_rbin_wide[PW-1:0];
  assign w_unused_hi = ^{w_gray_wide[GW-1:PW], w_rbin_wide[GW-1:PW]};

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray code that means the top two bits inverted, rest equal.
  assign w_full_cmp   = {~bus.wq2_rptr[PW-1:PW-2], bus.wq2_rptr[PW-3:0]};
  assign w_full_next  = (w_gray_next == w_full_cmp);
  assign w_level_next = w_wbin_next - w_rbin_s;
  assign w_af_next    = (w_level_next >= AF_CMP);

  // Overflow set wins over clear when both happen in one cycle.
  assign w_ovf_next = (bus.winc & r_full) | (r_ovf & ~bus.clr_ovf);

  // Pointer and flag registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wptr  <= w_gray_next;
      r_full  <= w_full_next;
      r_af    <= w_af_next;
      r_level <= w_level_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign bus.waddr        = r_wbin[ADDR_W-1:0];
  assign bus.wen          = w_wen;
  assign bus.wptr         = r_wptr;
  assign bus.wfull        = r_full;
  assign bus.walmost_full = r_af;
  assign bus.wlevel       = r_level;
  assign bus.woverflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for the FIFO write-side pointer/flag controller (ADDR_W=3, AF_LEVEL=6).
module tb_fifo_wptr_full;

  localparam int ADDR_W = 3;
  localparam int PW     = ADDR_W + 1;
  localparam int W      = 11;

  logic clk;
  logic rst_n;

  fifo_wptr_full_if #(.ADDR_W(ADDR_W)) bus ();

  fifo_wptr_full #(.ADDR_W(ADDR_W), .AF_LEVEL(6)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  // Behavioural model: write count and read count as plain integers.
  int   m_wbin;
  int   m_rbin;
  logic m_full;
  logic m_af;
  logic m_ovf;
  int   m_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_wbin = 0;
    m_rbin = 0;
    m_full = 1'b0;
    m_af   = 1'b0;
    m_ovf  = 1'b0;
    m_lvl  = 0;
  endtask

  // One clock of stimulus: drive at negedge, check combinational outputs,
  // push the model's post-edge prediction, then pop and compare after posedge.
  task automatic step(input logic winc_v, input int rbin_v, input logic clr_v);
    logic         acc;
    logic [3:0]   pre_wptr;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    @(negedge clk);
    m_rbin       = rbin_v % 16;
    bus.winc     = winc_v;
    bus.clr_ovf  = clr_v;
    bus.wq2_rptr = to_gray(m_rbin);
    #1;
    acc = winc_v & ~m_full;
    check("wen", {31'd0, bus.wen}, {31'd0, acc});
    check("waddr", {29'd0, bus.waddr}, m_wbin % 8);
    m_ovf  = (winc_v & m_full) ? 1'b1 : (clr_v ? 1'b0 : m_ovf);
    m_wbin = (m_wbin + (acc ? 1 : 0)) % 16;
    m_lvl  = (m_wbin - m_rbin + 16) % 16;
    m_full = (m_lvl == 8);
    m_af   = (m_lvl >= 6);
    exp_q.push_back({to_gray(m_wbin), m_full, m_af, m_lvl[3:0], m_ovf});
    pre_wptr = bus.wptr;
    @(posedge clk);
    #1;
    got = {bus.wptr, bus.wfull, bus.walmost_full, bus.wlevel, bus.woverflow};
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check("regs", {21'd0, got}, {21'd0, exp});
    end
    check("gray_step", ($countones(pre_wptr ^ bus.wptr) <= 1) ? 32'd1 : 32'd0, 32'd1);
    check("level_max", (bus.wlevel <= 4'd8) ? 32'd1 : 32'd0, 32'd1);
  endtask

  logic [3:0] fill_seq [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    fill_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    bus.winc     = 1'b0;
    bus.clr_ovf  = 1'b0;
    bus.wq2_rptr = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wptr", {28'd0, bus.wptr}, 32'd0);
    check("rst_full", {31'd0, bus.wfull}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream after five writes: must clear before the next edge.
    for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0);
    check("pre_rst_wptr", {28'd0, bus.wptr}, 32'd7);
    @(negedge clk);
    bus.winc = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wptr", {28'd0, bus.wptr}, 32'd0);
    check("arst_waddr", {29'd0, bus.waddr}, 32'd0);
    check("arst_wfull", {31'd0, bus.wfull}, 32'd0);
    check("arst_wlevel", {28'd0, bus.wlevel}, 32'd0);
    check("arst_wovf", {31'd0, bus.woverflow}, 32'd0);
    check("arst_waf", {31'd0, bus.walmost_full}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with the reader parked at 0.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 0, 1'b0);
      check("fill_wptr", {28'd0, bus.wptr}, {28'd0, fill_seq[i]});
      check("fill_af", {31'd0, bus.walmost_full}, (i >= 5) ? 32'd1 : 32'd0);
    end
    check("fill_full", {31'd0, bus.wfull}, 32'd1);
    check("fill_level", {28'd0, bus.wlevel}, 32'd8);

    // Overflow set / clear / set-beats-clear.
    step(1'b1, 0, 1'b0);
    check("ovf_wptr", {28'd0, bus.wptr}, 32'b1100);
    check("ovf_set", {31'd0, bus.woverflow}, 32'd1);
    step(1'b0, 0, 1'b1);
    check("ovf_clr", {31'd0, bus.woverflow}, 32'd0);
    step(1'b1, 0, 1'b1);
    check("ovf_prio", {31'd0, bus.woverflow}, 32'd1);

    // Drain visibility as the synchronized read pointer advances.
    step(1'b0, 1, 1'b1);
    check("drain1_full", {31'd0, bus.wfull}, 32'd0);
    check("drain1_lvl", {28'd0, bus.wlevel}, 32'd7);
    check("drain1_af", {31'd0, bus.walmost_full}, 32'd1);
    step(1'b0, 2, 1'b0);
    check("drain2_lvl", {28'd0, bus.wlevel}, 32'd6);
    step(1'b0, 3, 1'b0);
    check("drain3_lvl", {28'd0, bus.wlevel}, 32'd5);
    check("drain3_af", {31'd0, bus.walmost_full}, 32'd0);

    // Wrap-around: reader at 8, write until the binary pointer rolls to 0.
    step(1'b0, 8, 1'b0);
    check("wrap_empty_lvl", {28'd0, bus.wlevel}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 8, 1'b0);
    check("wrap_wptr", {28'd0, bus.wptr}, 32'd0);
    check("wrap_full", {31'd0, bus.wfull}, 32'd1);
    check("wrap_lvl", {28'd0, bus.wlevel}, 32'd8);
    step(1'b1, 8, 1'b0);
    check("wrap_ovf", {31'd0, bus.woverflow}, 32'd1);
    check("wrap_hold", {28'd0, bus.wptr}, 32'd0);

    // Random writes with a legally advancing read pointer.
    for (int i = 0; i < 10000; i++) begin
      int nr;
      nr = m_rbin;
      if ($urandom_range(0, 1) == 1 && nr != m_wbin) nr = (nr + 1) % 16;
      step(1'($urandom_range(0, 1)), nr, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
